addsub_sched: RTL and testbench
===============================

# addsub_sched

Round-robin scheduler that shares one 5-bit ripple add/subtract datapath between two requesters. Each requester presents operands and an add/subtract select under a req/ack handshake. The scheduler grants one requester, drives the shared adder's X, Y and C0 inputs from registers, and captures S, C5 and E. It then returns the result with a one-cycle ack. It sits between client logic and the existing add/sub datapath, which stays combinational and is instantiated outside this block.

## Interface
- WIDTH, 5, operand/result width; must match the shared datapath.

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req0, req1  in  1  request from requester 0/1; held high with stable operands until ack
- x0, y0, x1, y1  in  WIDTH  operands of requester 0/1
- sub0, sub1  in  1  0 = X+Y, 1 = X−Y (two's complement)
- ack0, ack1  out  1  one-cycle pulse; result outputs are valid in that cycle
- rs  out  WIDTH  registered result sum
- rc5  out  1  registered carry-out
- re  out  1  registered signed overflow (C5 xor C4)
- busy  out  1  high in ISSUE and DONE
- gnt  out  1  id of the current/last granted requester
- ax, ay  out  WIDTH  registered operands driven to the shared adder's X and Y
- ac0  out  1  registered carry-in/subtract to the shared adder's C0
- as, ac5, ae  in  WIDTH/1/1  S, C5, E returned from the shared adder

## Operation
- FSM with three states: IDLE, ISSUE, DONE.
- **IDLE:**
  - No req: stay in IDLE, registers hold.
  - Exactly one req: grant that requester.
  - Both req: grant the requester that was not granted last (`gnt` ≠ last grant).
  - On grant: ax←xK, ay←yK, ac0←subK, gnt←K, go to ISSUE.
- **ISSUE:** the adder settles. At the clock edge: rs←as, rc5←ac5, re←ae, ackK←1, go to DONE.
- **DONE:** ackK is high for this cycle only. Next edge: ack←0, go to IDLE.
- Requests are not sampled in ISSUE or DONE. Operand changes after the grant edge have no effect on the transaction in flight.
- A requester that keeps req high after its ack issues a new request. That request is evaluated in the next IDLE cycle and competes under round-robin.
- Arithmetic is done entirely by the external datapath:
  - Subtraction is X + ~Y + 1 with C0=1.
  - rc5=1 on a subtract means no borrow.
  - re flags signed 5-bit overflow.
- rs, rc5, re, ax, ay, ac0 and gnt hold their value until they are next updated.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE.
  - ack0=ack1=0, busy=0.
  - rs=0, rc5=0, re=0, ax=0, ay=0, ac0=0.
  - gnt=1, so requester 0 wins the first tie.
- Latency: req sampled in IDLE at edge N; ack high in the cycle after edge N+1; back in IDLE after edge N+2.
- Peak throughput: one operation per 3 cycles. Back-to-back requests from the same requester are granted at edges N, N+3, N+6, …
- Simultaneous requests alternate strictly: 0, 1, 0, 1, … A single requester that holds req continuously is never starved and is never blocked by an idle peer.
- Reset mid-operation (in ISSUE or DONE): the transaction is abandoned and no ack is issued. The requester must keep or re-raise req; it is served after reset is released.
- ack0 and ack1 are never high in the same cycle.
- busy is high exactly in the two cycles after a grant edge.

## Test plan
- **Reset state:** assert rst mid-cycle → all outputs 0, gnt=1, asynchronously and without waiting for a clock edge.
- **Add (requester 0 only):** x0=7, y0=5, sub0=0 → ack0 pulses 2 edges after the request is sampled; rs=01100, rc5=0, re=0.
- **Subtract, both signs:**
  - x0=5, y0=3, sub0=1 → rs=00010, rc5=1, re=0.
  - x0=3, y0=5, sub0=1 → rs=11110, rc5=0, re=0.
- **Overflow (requester 1):** x1=15, y1=15, sub1=0 → rs=11110, rc5=0, re=1, gnt=1.
- **Contention:** req0 and req1 held high from reset → grant order 0, 1, 0, 1. Acks land at cycles 3, 6, 9, 12 after reset release, never overlapping. Each result matches its own requester's operands.
- **Reset mid-transaction:** pulse rst while in ISSUE → no ack. After release, with req0 still high, the operation completes normally 3 cycles later with the correct result.

Source files
------------

// File: rtl/addsub_sched.sv
// Round-robin scheduler sharing one external combinational add/sub datapath between two requesters.
// Latency: grant at the edge that samples req, result registered one edge later, ack high for the following cycle.
// Backpressure: requests are held until ack; new requests are only sampled in IDLE, giving one operation per 3 cycles.
//
// Ports:
//   clk, rst            clock and asynchronous active-high reset
//   req0/1, x0/1, y0/1, sub0/1   requester handshake, operands, add/subtract select
//   ack0/1              one-cycle completion pulse, result valid in that cycle
//   rs, rc5, re         registered sum, carry-out, signed overflow
//   busy, gnt           transaction in flight, current/last granted requester
//   ax, ay, ac0         registered operands/carry-in driven to the shared adder
//   as, ac5, ae         sum, carry-out, overflow returned by the shared adder
module addsub_sched #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] x0,
    input  logic [WIDTH-1:0] y0,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] y1,
    input  logic             sub0,
    input  logic             sub1,
    output logic             ack0,
    output logic             ack1,
    output logic [WIDTH-1:0] rs,
    output logic             rc5,
    output logic             re,
    output logic             busy,
    output logic             gnt,
    output logic [WIDTH-1:0] ax,
    output logic [WIDTH-1:0] ay,
    output logic             ac0,
    input  logic [WIDTH-1:0] as,
    input  logic             ac5,
    input  logic             ae
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic grant_vld;
    logic grant_id;
    logic ack_set;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-cycle control
    always_comb begin
        state_nxt = state;
        grant_vld = 1'b0;
        grant_id  = gnt;
        ack_set   = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    grant_vld = 1'b1;
                    // On a tie the requester not granted last wins; gnt holds the last grant.
                    if (req0 && req1) begin
                        grant_id = ~gnt;
                    end else begin
                        grant_id = req1;
                    end
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                ack_set   = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand, result and handshake registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            rs   <= '0;
            rc5  <= 1'b0;
            re   <= 1'b0;
            ax   <= '0;
            ay   <= '0;
            ac0  <= 1'b0;
            // Pretend requester 1 was served last so requester 0 wins the first tie.
            gnt  <= 1'b1;
        end else begin
            // gnt is stable from grant through DONE, so it steers the ack.
            ack0 <= ack_set && !gnt;
            ack1 <= ack_set && gnt;
            if (grant_vld) begin
                ax  <= grant_id ? x1 : x0;
                ay  <= grant_id ? y1 : y0;
                ac0 <= grant_id ? sub1 : sub0;
                gnt <= grant_id;
            end
            if (ack_set) begin
                rs  <= as;
                rc5 <= ac5;
                re  <= ae;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_addsub_sched.sv
module tb_addsub_sched;

    localparam int W = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         req0, req1;
    logic [W-1:0] x0, y0, x1, y1;
    logic         sub0, sub1;
    logic         ack0, ack1;
    logic [W-1:0] rs;
    logic         rc5, re, busy, gnt;
    logic [W-1:0] ax, ay;
    logic         ac0;
    logic [W-1:0] as;
    logic         ac5, ae;

    int checks   = 0;
    int failures = 0;
    logic last;   // requester the reference model believes was granted last

    always #5 clk = ~clk;

    addsub_sched #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1),
        .sub0(sub0), .sub1(sub1),
        .ack0(ack0), .ack1(ack1),
        .rs(rs), .rc5(rc5), .re(re),
        .busy(busy), .gnt(gnt),
        .ax(ax), .ay(ay), .ac0(ac0),
        .as(as), .ac5(ac5), .ae(ae)
    );

    // External ripple add/sub datapath: X + (Y ^ C0) + C0, E = C5 ^ C4
    logic [4:0] yy;
    logic [5:0] s6;
    logic [4:0] s4;
    always_comb begin
        yy = ac0 ? ~ay : ay;
        s6 = {1'b0, ax} + {1'b0, yy} + {5'b0, ac0};
        s4 = {1'b0, ax[3:0]} + {1'b0, yy[3:0]} + {4'b0, ac0};
    end
    assign as  = s6[4:0];
    assign ac5 = s6[5];
    assign ae  = s6[5] ^ s4[4];

    // Reference arithmetic from integer semantics: returns {re, rc5, rs}
    function automatic logic [6:0] ref_op(input logic [4:0] x, input logic [4:0] y, input logic sub);
        int ux, uy, sx, sy, ur, sr;
        logic c, v;
        ux = int'(x);
        uy = int'(y);
        sx = (ux > 15) ? ux - 32 : ux;
        sy = (uy > 15) ? uy - 32 : uy;
        if (sub) begin
            ur = ux - uy;
            sr = sx - sy;
            c  = (ux >= uy);
        end else begin
            ur = ux + uy;
            sr = sx + sy;
            c  = (ur > 31);
        end
        v  = (sr > 15) || (sr < -16);
        ur = (ur + 64) % 32;
        return {v, c, ur[4:0]};
    endfunction

    // Round-robin rule: tie goes to the requester not served last
    function automatic logic pick(input logic r0, input logic r1, input logic lst);
        return (r0 && r1) ? ~lst : r1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rand_ops();
        x0   = 5'($urandom);
        y0   = 5'($urandom);
        sub0 = 1'($urandom);
        x1   = 5'($urandom);
        y1   = 5'($urandom);
        sub1 = 1'($urandom);
    endtask

    // Called at a negedge with the DUT in IDLE and requests already driven.
    // Follows one transaction for requester k over three negedges.
    task automatic expect_txn(input string tag, input logic k, input logic [4:0] x,
                              input logic [4:0] y, input logic sub);
        logic [6:0] r;
        r = ref_op(x, y, sub);
        @(negedge clk);
        chk({tag, ".issue_busy"}, 32'(busy), 32'd1);
        chk({tag, ".gnt"},        32'(gnt),  32'(k));
        chk({tag, ".ax"},         32'(ax),   32'(x));
        chk({tag, ".ay"},         32'(ay),   32'(y));
        chk({tag, ".ac0"},        32'(ac0),  32'(sub));
        chk({tag, ".issue_ack"},  32'({ack1, ack0}), 32'd0);
        // operands of the granted requester may now change freely
        if (k) begin
            x1 = 5'($urandom); y1 = 5'($urandom); sub1 = 1'($urandom);
        end else begin
            x0 = 5'($urandom); y0 = 5'($urandom); sub0 = 1'($urandom);
        end
        @(negedge clk);
        chk({tag, ".done_ack"},  32'({ack1, ack0}), k ? 32'd2 : 32'd1);
        chk({tag, ".done_busy"}, 32'(busy), 32'd1);
        chk({tag, ".rs"},        32'(rs),   32'(r[4:0]));
        chk({tag, ".rc5"},       32'(rc5),  32'(r[5]));
        chk({tag, ".re"},        32'(re),   32'(r[6]));
        @(negedge clk);
        chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
        chk({tag, ".idle_ack"},  32'({ack1, ack0}), 32'd0);
        last = k;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".ack"},  32'({ack1, ack0}), 32'd0);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".rs"},   32'(rs),   32'd0);
        chk({tag, ".rc5"},  32'(rc5),  32'd0);
        chk({tag, ".re"},   32'(re),   32'd0);
        chk({tag, ".ax"},   32'(ax),   32'd0);
        chk({tag, ".ay"},   32'(ay),   32'd0);
        chk({tag, ".ac0"},  32'(ac0),  32'd0);
        chk({tag, ".gnt"},  32'(gnt),  32'd1);
    endtask

    initial begin
        logic r0, r1, k;
        req0 = 1'b0; req1 = 1'b0;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0; sub0 = 1'b0; sub1 = 1'b0;
        last = 1'b1;

        // Power-up reset, observed before any clock edge
        #1 rst = 1'b1;
        #1 chk_reset_vals("por");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // No requests: nothing happens
        @(negedge clk);
        chk("noreq.busy", 32'(busy), 32'd0);
        chk("noreq.ack",  32'({ack1, ack0}), 32'd0);

        // Add on requester 0
        x0 = 5'd7; y0 = 5'd5; sub0 = 1'b0; req0 = 1'b1;
        expect_txn("add", 1'b0, 5'd7, 5'd5, 1'b0);
        req0 = 1'b0;
        chk("add.rs_const", 32'(rs), 32'b01100);
        chk("add.rc5_const", 32'(rc5), 32'd0);

        // Subtract, positive result
        x0 = 5'd5; y0 = 5'd3; sub0 = 1'b1; req0 = 1'b1;
        expect_txn("subpos", 1'b0, 5'd5, 5'd3, 1'b1);
        req0 = 1'b0;
        chk("subpos.rs_const",  32'(rs),  32'b00010);
        chk("subpos.rc5_const", 32'(rc5), 32'd1);

        // Subtract, negative result
        x0 = 5'd3; y0 = 5'd5; sub0 = 1'b1; req0 = 1'b1;
        expect_txn("subneg", 1'b0, 5'd3, 5'd5, 1'b1);
        req0 = 1'b0;
        chk("subneg.rs_const",  32'(rs),  32'b11110);
        chk("subneg.rc5_const", 32'(rc5), 32'd0);

        // Asynchronous reset mid-cycle, no clock edge involved
        #2 rst = 1'b1;
        #1 chk_reset_vals("async_rst");
        @(negedge clk);
        rst = 1'b0;
        last = 1'b1;

        // Overflow on requester 1
        x1 = 5'd15; y1 = 5'd15; sub1 = 1'b0; req1 = 1'b1;
        expect_txn("ovf", 1'b1, 5'd15, 5'd15, 1'b0);
        req1 = 1'b0;
        chk("ovf.rs_const", 32'(rs), 32'b11110);
        chk("ovf.re_const", 32'(re), 32'd1);
        chk("ovf.gnt_const", 32'(gnt), 32'd1);

        // Contention from reset: strict alternation 0,1,0,1
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last = 1'b1;
        rand_ops();
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            k = pick(1'b1, 1'b1, last);
            chk("rr.order", 32'(k), 32'(i % 2));
            if (k) expect_txn("rr", 1'b1, x1, y1, sub1);
            else   expect_txn("rr", 1'b0, x0, y0, sub0);
            rand_ops();
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);

        // Reset while in ISSUE: transaction abandoned, then served after release
        x0 = 5'd9; y0 = 5'd4; sub0 = 1'b1; req0 = 1'b1;
        @(negedge clk);
        chk("midrst.busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst.busy", 32'(busy), 32'd0);
        chk("midrst.ack",  32'({ack1, ack0}), 32'd0);
        @(negedge clk);
        chk("midrst.no_ack", 32'({ack1, ack0}), 32'd0);
        rst = 1'b0;
        last = 1'b1;
        expect_txn("midrst.retry", 1'b0, 5'd9, 5'd4, 1'b1);
        req0 = 1'b0;

        // Randomized traffic against the reference model
        for (int i = 0; i < 60; i++) begin
            r0 = 1'($urandom);
            r1 = 1'($urandom);
            rand_ops();
            req0 = r0; req1 = r1;
            if (!r0 && !r1) begin
                @(negedge clk);
                chk("rand.idle_busy", 32'(busy), 32'd0);
                chk("rand.idle_ack",  32'({ack1, ack0}), 32'd0);
                chk("rand.gnt_hold",  32'(gnt), 32'(last));
            end else begin
                k = pick(r0, r1, last);
                if (k) expect_txn("rand", 1'b1, x1, y1, sub1);
                else   expect_txn("rand", 1'b0, x0, y0, sub0);
            end
        end
        req0 = 1'b0; req1 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
